prio_index_encoder: RTL and testbench



---
 rtl/prio_index_encoder_if.sv | 24 ++
 rtl/prio_index_encoder.sv | 78 +++++++
 tb/tb_prio_index_encoder.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/prio_index_encoder_if.sv
// prio_index_encoder_if: capture bus for the registered index encoder
interface prio_index_encoder_if #(
    parameter int WIDTH    = 8,
    parameter int OH_WIDTH = 8
);
    localparam int CNT_W = (WIDTH == 1) ? 1 : $clog2(WIDTH);
    localparam int BIN_W = (OH_WIDTH == 1) ? 1 : $clog2(OH_WIDTH);
    logic                valid_i;
    logic [WIDTH-1:0]    in_i;
    logic [OH_WIDTH-1:0] onehot_i;
    logic                valid_o;
    logic [CNT_W-1:0]    cnt_o;
    logic                empty_o;
    logic [BIN_W-1:0]    bin_o;
    logic                onehot_err_o;
    modport master (
        output valid_i, in_i, onehot_i,
        input  valid_o, cnt_o, empty_o, bin_o, onehot_err_o
    );
    modport slave (
        input  valid_i, in_i, onehot_i,
        output valid_o, cnt_o, empty_o, bin_o, onehot_err_o
    );
endinterface

// File: rtl/prio_index_encoder.sv
// prio_index_encoder: registered first-set-bit counter and one-hot encoder (multi-hot flag under PRIO_INDEX_ENCODER_ONEHOT_CHECK_EN)
module prio_index_encoder #(
    parameter int WIDTH    = 8,
    parameter int MODE     = 0,
    parameter int OH_WIDTH = 8
) (
    input logic                   clk_i,
    input logic                   rst_ni,
    prio_index_encoder_if.slave   bus
);
    localparam int CNT_W = (WIDTH == 1) ? 1 : $clog2(WIDTH);
    localparam int BIN_W = (OH_WIDTH == 1) ? 1 : $clog2(OH_WIDTH);

    if (WIDTH < 1 || OH_WIDTH < 1 || MODE > 1) begin : g_bad_param
        $fatal(1, "prio_index_encoder: illegal parameters WIDTH=%0d OH_WIDTH=%0d MODE=%0d", WIDTH, OH_WIDTH, MODE);
    end

    logic [CNT_W-1:0] cnt;
    logic             empty;
    logic [BIN_W-1:0] bin;

    // zero count: the last hit in scan order wins, so scan toward the bit that must take priority
    always_comb begin
        cnt   = '0;
        empty = ~|bus.in_i;
        for (int i = WIDTH - 1; i >= 0; i--)
            if (MODE == 0 && bus.in_i[i]) cnt = CNT_W'(i);
        for (int i = 0; i < WIDTH; i++)
            if (MODE == 1 && bus.in_i[i]) cnt = CNT_W'(WIDTH - 1 - i);
    end

    // one-hot encode as the OR of set-bit indices; multi-hot inputs give a merged index
    always_comb begin
        bin = '0;
        for (int i = 0; i < OH_WIDTH; i++)
            if (bus.onehot_i[i]) bin = bin | BIN_W'(i);
    end

    // output stage: valid tracks every edge, data only loads on a valid capture
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bus.valid_o <= 1'b0;
            bus.cnt_o   <= '0;
            bus.empty_o <= 1'b1;
            bus.bin_o   <= '0;
        end else begin
            bus.valid_o <= bus.valid_i;
            if (bus.valid_i) begin
                bus.cnt_o   <= cnt;
                bus.empty_o <= empty;
                bus.bin_o   <= bin;
            end
        end
    end

`ifdef PRIO_INDEX_ENCODER_ONEHOT_CHECK_EN
    logic multi;

    // multi-hot detect: a set bit seen after an earlier set bit means popcount > 1
    always_comb begin
        logic seen;
        seen  = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < OH_WIDTH; i++) begin
            multi = multi | (seen & bus.onehot_i[i]);
            seen  = seen | bus.onehot_i[i];
        end
    end

    // error flag follows the same capture rule as the data outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) bus.onehot_err_o <= 1'b0;
        else if (bus.valid_i) bus.onehot_err_o <= multi;
    end
`else
    assign bus.onehot_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_prio_index_encoder.sv
// tb_prio_index_encoder: directed and random checks of both scan modes against a behavioural model
module tb_prio_index_encoder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       valid = 1'b0;
    logic [7:0] vec = '0;
    logic [7:0] oh = '0;
    int         n_vec = 0;
    int         n_bad = 0;

    logic       e_valid;
    int         e_cnt0, e_cnt1, e_bin;
    logic       e_empty, e_err;

    always #5 clk = ~clk;

    prio_index_encoder_if #(.WIDTH(8), .OH_WIDTH(8)) bus0 ();
    prio_index_encoder_if #(.WIDTH(8), .OH_WIDTH(8)) bus1 ();

    assign bus0.valid_i  = valid;
    assign bus0.in_i     = vec;
    assign bus0.onehot_i = oh;
    assign bus1.valid_i  = valid;
    assign bus1.in_i     = vec;
    assign bus1.onehot_i = oh;

    prio_index_encoder #(.WIDTH(8), .MODE(0), .OH_WIDTH(8)) u0 (.clk_i(clk), .rst_ni(rst_n), .bus(bus0));
    prio_index_encoder #(.WIDTH(8), .MODE(1), .OH_WIDTH(8)) u1 (.clk_i(clk), .rst_ni(rst_n), .bus(bus1));

    function automatic int trailing(input logic [7:0] v);
        int n = 0;
        if (v == 0) return 0;
        while (!v[n]) n++;
        return n;
    endfunction

    function automatic int leading(input logic [7:0] v);
        int n = 0;
        if (v == 0) return 0;
        while (!v[7 - n]) n++;
        return n;
    endfunction

    function automatic int or_index(input logic [7:0] v);
        int r = 0;
        for (int i = 0; i < 8; i++) if (v[i]) r = r | i;
        return r;
    endfunction

    function automatic logic multi_hot(input logic [7:0] v);
`ifdef PRIO_INDEX_ENCODER_ONEHOT_CHECK_EN
        return $countones(v) > 1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        e_valid = 1'b0; e_cnt0 = 0; e_cnt1 = 0; e_empty = 1'b1; e_bin = 0; e_err = 1'b0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".valid0"}, 32'(bus0.valid_o), 32'(e_valid));
        check({tag, ".valid1"}, 32'(bus1.valid_o), 32'(e_valid));
        check({tag, ".cnt0"},   32'(bus0.cnt_o),   32'(e_cnt0));
        check({tag, ".cnt1"},   32'(bus1.cnt_o),   32'(e_cnt1));
        check({tag, ".empty0"}, 32'(bus0.empty_o), 32'(e_empty));
        check({tag, ".empty1"}, 32'(bus1.empty_o), 32'(e_empty));
        check({tag, ".bin0"},   32'(bus0.bin_o),   32'(e_bin));
        check({tag, ".bin1"},   32'(bus1.bin_o),   32'(e_bin));
        check({tag, ".err0"},   32'(bus0.onehot_err_o), 32'(e_err));
        check({tag, ".err1"},   32'(bus1.onehot_err_o), 32'(e_err));
    endtask

    task automatic step(input string tag, input logic v, input logic [7:0] a, input logic [7:0] o);
        valid = v; vec = a; oh = o;
        @(posedge clk);
        #1;
        e_valid = v;
        if (v) begin
            e_cnt0 = trailing(a); e_cnt1 = leading(a); e_empty = (a == 0);
            e_bin = or_index(o); e_err = multi_hot(o);
        end
        check_all(tag);
    endtask

    initial begin
        vec = 8'($urandom); oh = 8'($urandom); valid = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("reset");
        #1 rst_n = 1'b1; valid = 1'b0;

        step("lsb_28", 1'b1, 8'b0010_1000, 8'b0100_0000);
        check("tp_cnt0_3", 32'(bus0.cnt_o), 32'd3);
        check("tp_cnt1_2", 32'(bus1.cnt_o), 32'd2);
        check("tp_bin_6",  32'(bus0.bin_o), 32'd6);
        check("tp_err_0",  32'(bus0.onehot_err_o), 32'd0);
        step("msb_80", 1'b1, 8'b1000_0000, 8'b0000_0110);
        check("tp_cnt0_7", 32'(bus0.cnt_o), 32'd7);
        check("tp_bin_3",  32'(bus0.bin_o), 32'd3);
`ifdef PRIO_INDEX_ENCODER_ONEHOT_CHECK_EN
        check("tp_err_1",  32'(bus0.onehot_err_o), 32'd1);
`else
        check("tp_err_off", 32'(bus0.onehot_err_o), 32'd0);
`endif
        step("lsb_01", 1'b1, 8'b0000_0001, 8'b0000_0001);
        check("tp_cnt1_7", 32'(bus1.cnt_o), 32'd7);
        step("zero", 1'b1, 8'b0000_0000, 8'b0000_0000);
        check("tp_empty0", 32'(bus0.empty_o), 32'd1);
        check("tp_empty1", 32'(bus1.empty_o), 32'd1);
        check("tp_zcnt1",  32'(bus1.cnt_o), 32'd0);

        step("hold_load", 1'b1, 8'b0000_0100, 8'b0000_1000);
        for (int i = 0; i < 3; i++) begin
            step("hold", 1'b0, 8'b1000_0000, 8'b1000_0000);
            check("tp_hold_cnt0", 32'(bus0.cnt_o), 32'd2);
            check("tp_hold_valid", 32'(bus0.valid_o), 32'd0);
        end

        step("pre_rst", 1'b1, 8'b0010_0000, 8'b0001_0000);
        check("tp_cnt0_5", 32'(bus0.cnt_o), 32'd5);
        check("tp_bin_4",  32'(bus0.bin_o), 32'd4);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("mid_rst");
        #1 rst_n = 1'b1;
        step("post_rst_idle", 1'b0, 8'b0000_0010, 8'b0000_0010);
        step("post_rst_cap", 1'b1, 8'b0000_0010, 8'b0000_0010);

        for (int k = 0; k < 300; k++) begin
            logic [7:0] a, o;
            a = 8'($urandom);
            if ($urandom_range(0, 5) == 0) a = 8'h00;
            else if ($urandom_range(0, 3) == 0) a = 8'(1) << $urandom_range(0, 7);
            o = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'(8'(1) << $urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) o = 8'h00;
            step("rand", 1'($urandom_range(0, 3) != 0), a, o);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
